// File: rtl/hex_disp_pkg.sv
// rtl/hex_disp_pkg.sv - shared types and glyph table for the HEX display controller
// Holds the seg_t type, the blank pattern, the 16-entry active-low glyph
// table (bit 6 = segment a, bit 0 = segment g) and the controller FSM states.
package hex_disp_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'b1111111;

  localparam seg_t GLYPHS [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_UPDATE = 1'b1
  } state_e;

endpackage

// File: rtl/hex_digit_decode.sv
// rtl/hex_digit_decode.sv - combinational hex nibble to seven-segment glyph
// Ports:
//   nibble_i  in  4  hex digit value
//   seg_o     out 7  active-low segments, bit 6 = a .. bit 0 = g
module hex_digit_decode
  import hex_disp_pkg::*;
(
  input  logic [3:0] nibble_i,
  output seg_t       seg_o
);

  assign seg_o = GLYPHS[nibble_i];

endmodule

// File: rtl/hex_display_ctrl.sv
// rtl/hex_display_ctrl.sv - registered multi-digit seven-segment display controller
// Captures a full multi-digit value in one handshake, decodes it one cycle
// later, applies leading-zero blanking and per-digit blink, and drives
// registered active-low segments.
// Optional feature macro: HEX_DISP_BLINK_EN (blink counter, phase and mask).
// Ports:
//   CLOCK_50       in  1          clock
//   reset          in  1          synchronous active-high reset
//   wr_valid       in  1          write request
//   wr_ready       out 1          write can be accepted
//   wr_data        in  4*DIGITS   hex nibbles, digit i = wr_data[4i+3:4i]
//   wr_lz_blank    in  1          leading-zero blanking enable
//   wr_blink_mask  in  DIGITS     per-digit blink enable
//   seg            out 7*DIGITS   active-low segments, digit i = seg[7i+6:7i]
module hex_display_ctrl
  import hex_disp_pkg::*;
#(
  parameter int DIGITS    = 6,
  parameter int BLINK_DIV = 25000000
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [4*DIGITS-1:0]   wr_data,
  input  logic                  wr_lz_blank,
  input  logic [DIGITS-1:0]     wr_blink_mask,
  output logic [7*DIGITS-1:0]   seg
);

  state_e                state_q;
  logic                  ready_q;
  logic [4*DIGITS-1:0]   data_q;
  logic                  lz_q;
  logic                  shown_q;
  logic [7*DIGITS-1:0]   seg_q;
  logic [7*DIGITS-1:0]   seg_d;
  logic [DIGITS-1:0]     blink_mask;
  logic                  phase;

  seg_t                  glyph [DIGITS];
  seg_t                  digit;
  logic                  lead;

`ifdef HEX_DISP_BLINK_EN
  localparam int CNT_W = $clog2(BLINK_DIV);

  logic [CNT_W-1:0]      cnt_q;
  logic                  phase_q;
  logic [DIGITS-1:0]     mask_q;

  // Free-running blink timebase; writes never touch it.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else if (cnt_q == CNT_W'(BLINK_DIV - 1)) begin
      cnt_q   <= '0;
      phase_q <= ~phase_q;
    end else begin
      cnt_q   <= cnt_q + 1'b1;
    end
  end

  assign phase      = phase_q;
  assign blink_mask = mask_q;
`else
  localparam int unused_blink_div = BLINK_DIV;
  logic unused_mask;

  assign unused_mask = ^wr_blink_mask;
  assign phase       = 1'b0;
  assign blink_mask  = '0;
`endif

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_dec
    hex_digit_decode u_dec (
      .nibble_i (data_q[4*gi +: 4]),
      .seg_o    (glyph[gi])
    );
  end

  // Scan from the top digit down: blanking stays active only while every
  // digit seen so far is zero; digit 0 always shows.
  always_comb begin
    seg_d = '0;
    lead  = lz_q;
    digit = SEG_BLANK;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      digit = glyph[i];
      if (lead && (i != 0) && (data_q[4*i +: 4] == 4'h0)) begin
        digit = SEG_BLANK;
      end else begin
        lead = 1'b0;
      end
      if (phase && blink_mask[i]) begin
        digit = SEG_BLANK;
      end
      seg_d[7*i +: 7] = digit;
    end
    // Nothing has been written since reset: keep the display dark.
    if (!(shown_q || (state_q == ST_UPDATE))) begin
      seg_d = {DIGITS{SEG_BLANK}};
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b0;
      data_q  <= '0;
      lz_q    <= 1'b0;
      shown_q <= 1'b0;
      seg_q   <= {DIGITS{SEG_BLANK}};
`ifdef HEX_DISP_BLINK_EN
      mask_q  <= '0;
`endif
    end else begin
      // Recomputed every cycle so blink follows the phase bit.
      seg_q <= seg_d;
      case (state_q)
        ST_IDLE: begin
          if (wr_valid && ready_q) begin
            data_q  <= wr_data;
            lz_q    <= wr_lz_blank;
`ifdef HEX_DISP_BLINK_EN
            mask_q  <= wr_blink_mask;
`endif
            ready_q <= 1'b0;
            state_q <= ST_UPDATE;
          end else begin
            ready_q <= 1'b1;
          end
        end
        ST_UPDATE: begin
          shown_q <= 1'b1;
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: begin
          ready_q <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign seg      = seg_q;
  assign wr_ready = ready_q;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// tb/tb_hex_display_ctrl.sv - self-checking bench for hex_display_ctrl
module tb_hex_display_ctrl;

  localparam int ND = 6;
  localparam int BD = 4;

  logic            CLOCK_50 = 1'b0;
  logic            reset;
  logic            wr_valid;
  logic            wr_ready;
  logic [4*ND-1:0] wr_data;
  logic            wr_lz_blank;
  logic [ND-1:0]   wr_blink_mask;
  logic [7*ND-1:0] seg;

  int checks   = 0;
  int failures = 0;
  int edge_cnt = 0;

  logic [23:0] disp_val  = '0;
  bit          disp_lz   = 1'b0;
  logic [5:0]  disp_mask = '0;
  bit          shown     = 1'b0;

  logic [6:0] gly [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  hex_display_ctrl #(.DIGITS(ND), .BLINK_DIV(BD)) dut (
    .CLOCK_50      (CLOCK_50),
    .reset         (reset),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_data       (wr_data),
    .wr_lz_blank   (wr_lz_blank),
    .wr_blink_mask (wr_blink_mask),
    .seg           (seg)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Edges seen since reset was last released.
  always @(posedge CLOCK_50) begin
    if (reset) edge_cnt <= 0;
    else       edge_cnt <= edge_cnt + 1;
  end

  // Phase in effect on seg after k edges: blink period BD edges, seg lags one edge.
  function automatic bit phase_after(input int k);
`ifdef HEX_DISP_BLINK_EN
    if (k < 1) return 1'b0;
    return bit'(((k - 1) / BD) % 2);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [41:0] model_seg(input logic [23:0] v, input bit lz,
                                            input logic [5:0] m, input bit ph);
    logic [41:0] r;
    logic [6:0]  g;
    r = '0;
    for (int i = 0; i < ND; i++) begin
      g = gly[(v >> (4 * i)) & 24'hF];
      if (lz && i > 0 && (v >> (4 * i)) == 24'd0) g = 7'h7F;
`ifdef HEX_DISP_BLINK_EN
      if (ph && m[i]) g = 7'h7F;
`endif
      r[7*i +: 7] = g;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_seg(input string tag);
    logic [41:0] e;
    if (!shown) e = '1;
    else        e = model_seg(disp_val, disp_lz, disp_mask, phase_after(edge_cnt));
    chk(tag, {22'd0, seg}, {22'd0, e});
  endtask

  // Entered and left at a negedge with the controller idle.
  task automatic do_write(input string tag, input logic [23:0] d, input bit lz, input logic [5:0] m);
    chk({tag, "_ready_idle"}, {63'd0, wr_ready}, 64'd1);
    wr_valid = 1'b1; wr_data = d; wr_lz_blank = lz; wr_blink_mask = m;
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    wr_valid = 1'b0; wr_data = $urandom();
    chk({tag, "_ready_busy"}, {63'd0, wr_ready}, 64'd0);
    check_seg({tag, "_seg_old"});
    @(negedge CLOCK_50);
    disp_val = d; disp_lz = lz; disp_mask = m; shown = 1'b1;
    chk({tag, "_ready_back"}, {63'd0, wr_ready}, 64'd1);
    check_seg({tag, "_seg_new"});
  endtask

  logic [23:0] sv [10];
  bit          sl [10];
  logic [5:0]  sm [10];
  logic [23:0] full = 24'hFFFFFF;
  logic [23:0] rd;
  int          idx;

  initial begin
    reset = 1'b1; wr_valid = 1'b0; wr_data = '0; wr_lz_blank = 1'b0; wr_blink_mask = '0;

    // Reset state
    repeat (3) @(negedge CLOCK_50);
    chk("rst_seg", {22'd0, seg}, {22'd0, {42{1'b1}}});
    chk("rst_ready", {63'd0, wr_ready}, 64'd0);
    reset = 1'b0;
    @(negedge CLOCK_50);
    chk("rel_ready", {63'd0, wr_ready}, 64'd1);
    check_seg("rel_seg_blank");

    // Plain decode
    do_write("w123abc", 24'h123ABC, 1'b0, 6'd0);
    chk("w123abc_d0", {57'd0, seg[6:0]}, {57'd0, 7'b0110001});
    chk("w123abc_d5", {57'd0, seg[41:35]}, {57'd0, 7'b1001111});

    // Leading-zero blanking
    do_write("lz40", 24'h000040, 1'b1, 6'd0);
    chk("lz40_d1", {57'd0, seg[13:7]}, {57'd0, 7'b1001100});
    do_write("lz00", 24'h000000, 1'b1, 6'd0);
    chk("lz00_all", {22'd0, seg}, {22'd0, {35{1'b1}}, 7'b0000001});

    // Blink on digit 0
    do_write("blink7", 24'h000007, 1'b0, 6'b000001);
    for (int c = 0; c < 20; c++) begin
      @(negedge CLOCK_50);
      check_seg($sformatf("blink7_c%0d", c));
    end

    // Random writes with random leading zeros, lz and masks
    for (int w = 0; w < 8; w++) begin
      rd = 24'($urandom()) & (full >> (4 * $urandom_range(0, 6)));
      do_write($sformatf("rnd%0d", w), rd, bit'($urandom_range(0, 1)), 6'($urandom()));
      repeat ($urandom_range(1, 5)) begin
        @(negedge CLOCK_50);
        check_seg($sformatf("rnd%0d_hold", w));
      end
    end

    // wr_valid held high with fresh data every cycle
    for (int i = 0; i < 10; i++) begin
      sv[i] = 24'($urandom()) & (full >> (4 * $urandom_range(0, 5)));
      sl[i] = bit'($urandom_range(0, 1));
      sm[i] = 6'($urandom());
    end
    for (int i = 0; i <= 10; i++) begin
      if (i >= 2) begin
        idx = ((i - 2) / 2) * 2;
        disp_val = sv[idx]; disp_lz = sl[idx]; disp_mask = sm[idx];
      end
      chk($sformatf("strm%0d_ready", i), {63'd0, wr_ready}, {63'd0, (i % 2) == 0});
      check_seg($sformatf("strm%0d_seg", i));
      if (i < 10) begin
        wr_valid = 1'b1; wr_data = sv[i]; wr_lz_blank = sl[i]; wr_blink_mask = sm[i];
      end else begin
        wr_valid = 1'b0;
      end
      @(negedge CLOCK_50);
    end
    check_seg("strm_tail_seg");

    // Reset together with wr_valid
    wr_valid = 1'b1; wr_data = 24'hFEDCBA; reset = 1'b1;
    @(negedge CLOCK_50);
    shown = 1'b0;
    chk("rstv_seg", {22'd0, seg}, {22'd0, {42{1'b1}}});
    chk("rstv_ready", {63'd0, wr_ready}, 64'd0);
    reset = 1'b0; wr_valid = 1'b0;
    @(negedge CLOCK_50);
    check_seg("rstv_rel_seg");
    do_write("post1", 24'h00BEEF, 1'b1, 6'd0);

    // Reset in the middle of an update
    chk("mid_ready", {63'd0, wr_ready}, 64'd1);
    wr_valid = 1'b1; wr_data = 24'h987654; wr_lz_blank = 1'b0; wr_blink_mask = 6'd0;
    @(negedge CLOCK_50);
    reset = 1'b1; wr_data = 24'h111111;
    @(negedge CLOCK_50);
    shown = 1'b0;
    chk("mid_rst_seg", {22'd0, seg}, {22'd0, {42{1'b1}}});
    chk("mid_rst_ready", {63'd0, wr_ready}, 64'd0);
    reset = 1'b0; wr_valid = 1'b0;
    @(negedge CLOCK_50);
    chk("mid_rel_ready", {63'd0, wr_ready}, 64'd1);
    check_seg("mid_rel_seg");
    @(negedge CLOCK_50);
    check_seg("mid_rel_seg2");
    do_write("post2", 24'h0A0B0C, 1'b1, 6'b100001);
    repeat (6) begin
      @(negedge CLOCK_50);
      check_seg("post2_hold");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
